// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: E-stage MDU issue gating, latency countdown interlock, HI/LO read mux and busy-sync checker
module e_mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [2:0]  E_MDUOp,
  input  logic        E_HiLoSel,
  input  logic        D_IsMD,
  input  logic        MDU_Busy,
  input  logic [31:0] MDU_HI,
  input  logic [31:0] MDU_LO,
  output logic        MDU_Start,
  output logic [2:0]  MDU_Op,
  output logic        Stall,
  output logic [31:0] MDU_Rd,
  output logic        Busy_Pred,
  output logic        Sync_Err
);
  typedef enum logic {KIND_MULT = 1'b0, KIND_DIV = 1'b1} kind_t;
  logic [3:0] cnt;
  kind_t      kind;
  logic       is_muldiv;
  logic       is_div;
  logic       issue;
  // issue gating, interlock and read mux; Req cancels only the command in E, never a running countdown
  always_comb begin
    is_muldiv = (E_MDUOp >= 3'd1) && (E_MDUOp <= 3'd4);
    is_div    = (E_MDUOp == 3'd3) || (E_MDUOp == 3'd4);
    Busy_Pred = cnt != 4'd0;
    issue     = is_muldiv & ~Req & ~Busy_Pred;
    MDU_Start = issue;
    MDU_Op    = Req ? 3'd0 : E_MDUOp;
    Stall     = D_IsMD & (issue | Busy_Pred);
    MDU_Rd    = E_HiLoSel ? MDU_HI : MDU_LO;
  end
  // latency countdown loaded on issue, saturating at zero, plus sticky busy-mismatch flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 4'd0;
      kind     <= KIND_MULT;
      Sync_Err <= 1'b0;
    end else begin
      Sync_Err <= Sync_Err | (Busy_Pred != MDU_Busy);
      if (issue) begin
        cnt  <= is_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
        kind <= is_div ? KIND_DIV : KIND_MULT;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      assert (cnt <= (kind == KIND_DIV ? 4'(DIV_LAT) : 4'(MULT_LAT)));
    end
  end
endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb_e_mdu_ctrl: directed vectors against e_mdu_ctrl with a behavioural MDU supplying Busy/HI/LO
module tb_e_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Req = 1'b0;
  logic [2:0]  E_MDUOp = 3'd0;
  logic        E_HiLoSel = 1'b0;
  logic        D_IsMD = 1'b0;
  logic        MDU_Busy;
  logic [31:0] MDU_HI;
  logic [31:0] MDU_LO;
  logic        MDU_Start;
  logic [2:0]  MDU_Op;
  logic        Stall;
  logic [31:0] MDU_Rd;
  logic        Busy_Pred;
  logic        Sync_Err;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd1;
  logic [3:0]  mcnt;
  logic        early_drop = 1'b0;

  e_mdu_ctrl dut (
    .clk(clk), .reset(reset), .Req(Req), .E_MDUOp(E_MDUOp), .E_HiLoSel(E_HiLoSel),
    .D_IsMD(D_IsMD), .MDU_Busy(MDU_Busy), .MDU_HI(MDU_HI), .MDU_LO(MDU_LO),
    .MDU_Start(MDU_Start), .MDU_Op(MDU_Op), .Stall(Stall), .MDU_Rd(MDU_Rd),
    .Busy_Pred(Busy_Pred), .Sync_Err(Sync_Err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      mcnt   <= 4'd0;
      MDU_HI <= 32'd0;
      MDU_LO <= 32'd0;
    end else if (MDU_Start) begin
      mcnt <= (MDU_Op >= 3'd3) ? 4'd10 : 4'd5;
      if (MDU_Op >= 3'd3) begin
        MDU_LO <= op_a / op_b;
        MDU_HI <= op_a % op_b;
      end else begin
        {MDU_HI, MDU_LO} <= 64'(op_a) * 64'(op_b);
      end
    end else if (mcnt != 4'd0) begin
      mcnt <= mcnt - 4'd1;
    end
  end
  assign MDU_Busy = (mcnt != 4'd0) & ~early_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(Busy_Pred), 0);
    chk("rst_syncerr", 32'(Sync_Err), 0);
    chk("rst_start", 32'(MDU_Start), 0);
    chk("rst_stall", 32'(Stall), 0);

    // mult with dependent instruction in D: 6 stall cycles, busy in T+1..T+5
    tick();
    E_MDUOp = 3'd1; D_IsMD = 1'b1; op_a = 32'd6; op_b = 32'd7;
    #1;
    chk("mult_start", 32'(MDU_Start), 1);
    chk("mult_op", 32'(MDU_Op), 1);
    chk("mult_stall_T", 32'(Stall), 1);
    chk("mult_busy_T", 32'(Busy_Pred), 0);
    tick();
    E_MDUOp = 3'd0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      chk("mult_busy", 32'(Busy_Pred), 1);
      chk("mult_stall", 32'(Stall), 1);
      chk("mult_nostart", 32'(MDU_Start), 0);
      tick();
    end
    chk("mult_busy_end", 32'(Busy_Pred), 0);
    chk("mult_stall_end", 32'(Stall), 0);
    E_MDUOp = 3'd7; E_HiLoSel = 1'b0;
    #1;
    chk("mult_lo", MDU_Rd, 42);
    chk("mult_syncerr", 32'(Sync_Err), 0);

    // div 100/7 then mfread of LO and HI
    tick();
    E_MDUOp = 3'd3; op_a = 32'd100; op_b = 32'd7;
    #1;
    chk("div_start", 32'(MDU_Start), 1);
    tick();
    E_MDUOp = 3'd0;
    for (int k = 1; k <= 10; k++) begin
      chk("div_busy", 32'(Busy_Pred), 1);
      tick();
    end
    chk("div_busy_end", 32'(Busy_Pred), 0);
    E_MDUOp = 3'd7; E_HiLoSel = 1'b0;
    #1;
    chk("div_lo", MDU_Rd, 14);
    E_HiLoSel = 1'b1;
    #1;
    chk("div_hi", MDU_Rd, 2);
    chk("div_syncerr", 32'(Sync_Err), 0);

    // Req cancels a divu in E
    tick();
    Req = 1'b1; E_MDUOp = 3'd4;
    #1;
    chk("req_start", 32'(MDU_Start), 0);
    chk("req_op", 32'(MDU_Op), 0);
    chk("req_stall", 32'(Stall), 0);
    tick();
    Req = 1'b0; E_MDUOp = 3'd0;
    #1;
    chk("req_busy", 32'(Busy_Pred), 0);

    // mthi passes through without starting or stalling
    E_MDUOp = 3'd5;
    #1;
    chk("mthi_op", 32'(MDU_Op), 5);
    chk("mthi_start", 32'(MDU_Start), 0);
    chk("mthi_stall", 32'(Stall), 0);
    tick();
    chk("mthi_busy", 32'(Busy_Pred), 0);

    // Req at cycle 3 of a mult countdown does not stop it
    E_MDUOp = 3'd2;
    #1;
    chk("mreq_start", 32'(MDU_Start), 1);
    tick();
    E_MDUOp = 3'd0;
    tick();
    tick();
    Req = 1'b1; E_MDUOp = 3'd6;
    #1;
    chk("mreq_op", 32'(MDU_Op), 0);
    chk("mreq_busy3", 32'(Busy_Pred), 1);
    tick();
    Req = 1'b0; E_MDUOp = 3'd0;
    chk("mreq_busy4", 32'(Busy_Pred), 1);
    tick();
    chk("mreq_busy5", 32'(Busy_Pred), 1);
    tick();
    chk("mreq_busy6", 32'(Busy_Pred), 0);
    chk("mreq_syncerr", 32'(Sync_Err), 0);

    // reset when a div countdown sits at 7
    E_MDUOp = 3'd3;
    tick();
    E_MDUOp = 3'd0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rdiv_busy_pre", 32'(Busy_Pred), 1);
    tick();
    chk("rdiv_busy", 32'(Busy_Pred), 0);
    chk("rdiv_stall", 32'(Stall), 0);
    chk("rdiv_syncerr", 32'(Sync_Err), 0);
    reset = 1'b0;

    // MDU drops Busy one cycle early: sticky Sync_Err until reset
    tick();
    E_MDUOp = 3'd1;
    tick();
    E_MDUOp = 3'd0;
    tick();
    tick();
    tick();
    tick();
    early_drop = 1'b1;
    #1;
    chk("sync_pre", 32'(Sync_Err), 0);
    tick();
    early_drop = 1'b0;
    chk("sync_rise", 32'(Sync_Err), 1);
    tick();
    tick();
    chk("sync_hold", 32'(Sync_Err), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("sync_clr", 32'(Sync_Err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/e_mdu_ctrl.md
# e_mdu_ctrl

E-stage issue and interlock controller for the multiply/divide unit. Sits between the E-stage pipeline register and the MDU. It gates MDU commands on exception requests and tracks the MDU latency with its own countdown, so D-stage multiply/divide-class instructions are stalled from the issue cycle onward. It also returns HI/LO for mfhi/mflo and flags any divergence between its predicted busy state and the MDU's reported Busy.

## Interface
Parameters:
- MULT_LAT, 5, cycles MDU Busy stays high after a mult/multu issue
- DIV_LAT, 10, cycles MDU Busy stays high after a div/divu issue

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Req  in  1  exception/interrupt request; cancels the E-stage MDU command this cycle
- E_MDUOp  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfread
- E_HiLoSel  in  1  for mfread: 1 = HI, 0 = LO
- D_IsMD  in  1  D-stage instruction is any MDU-class op (opcodes 1..7)
- MDU_Busy  in  1  Busy from the MDU
- MDU_HI  in  32  HI from the MDU
- MDU_LO  in  32  LO from the MDU
- MDU_Start  out  1  start pulse to the MDU
- MDU_Op  out  3  op to the MDU (0 when cancelled)
- Stall  out  1  stall request to the hazard unit (freeze F/D, bubble E)
- MDU_Rd  out  32  HI or LO for mfread
- Busy_Pred  out  1  predicted busy, equals cnt != 0
- Sync_Err  out  1  sticky flag: prediction and MDU_Busy disagreed

## Operation
- cancel = Req.
- issue = (E_MDUOp in 1..4) & ~cancel & ~Busy_Pred.
- MDU_Start = issue. It is never asserted while Busy_Pred = 1.
- MDU_Op = cancel ? 0 : E_MDUOp. mthi/mtlo pass through only when Req = 0.
- States: IDLE (cnt = 0), MULT (cnt loaded from MULT_LAT), DIV (cnt loaded from DIV_LAT). The state is encoded in a 4-bit counter cnt plus a 1-bit kind register.
- Transitions:
  - IDLE -> MULT on issue with op 1/2: cnt <= MULT_LAT.
  - IDLE -> DIV on issue with op 3/4: cnt <= DIV_LAT.
  - MULT/DIV: cnt <= cnt - 1 every cycle.
  - cnt reaching 0 -> IDLE.
- Req while cnt != 0 does not stop the countdown. The MDU completes the operation.
- Stall = D_IsMD & (issue | Busy_Pred). An MDU op in E that is also stalled in D (E_MDUOp in 1..4 while Busy_Pred = 1) cannot occur, because the preceding stall holds it in D.
- MDU_Rd = E_HiLoSel ? MDU_HI : MDU_LO. This path is combinational and valid whenever Busy_Pred = 0.
- Sync_Err <= Sync_Err | (Busy_Pred != MDU_Busy), sampled every cycle after reset. It clears only on reset.

## Timing
- Reset values: cnt = 0, kind = 0, Sync_Err = 0. Hence Busy_Pred = 0, MDU_Start = issue, Stall = D_IsMD & issue.
- Issue cycle T (edge at end of T loads cnt):
  - Stall is high in T if D_IsMD.
  - Busy_Pred is high in T+1 .. T+LAT.
  - Busy_Pred is low in T+LAT+1.
  - This matches MDU_Busy exactly, so no Sync_Err for a correct MDU.
- An MDU-class instruction in D during T+LAT+1 proceeds. An mfread reaching E in that cycle reads the new HI/LO.
- Total D-stage stall for a dependent instruction directly behind mult: 1 + MULT_LAT = 6 cycles. Behind div: 11 cycles.
- Req and issue in the same cycle: no MDU_Start, MDU_Op = 0, cnt unchanged, Stall = D_IsMD & Busy_Pred.
- mthi/mtlo take effect at the MDU on the issue edge. They never raise Busy_Pred and do not stall.
- Reset mid-operation: cnt = 0 on the next edge, so Busy_Pred and Stall drop in the following cycle. The MDU is reset by the same signal.
- Wrap-around is impossible: the counter holds 0 and never decrements below it. With the default parameters cnt fits in 4 bits (DIV_LAT ≤ 15).

## Test plan
- Reset, then mult (op 1) with D_IsMD = 1 -> MDU_Start = 1 one cycle; Stall high for 6 cycles; Busy_Pred high for cycles 1..5; Sync_Err = 0.
- div (op 3), then mfread with E_HiLoSel = 0 after the stall -> Busy_Pred high for 10 cycles; MDU_Rd equals the quotient (e.g. A = 100, B = 7 gives LO = 14, HI = 2).
- Req = 1 with E_MDUOp = 4 -> MDU_Start = 0, MDU_Op = 0, Busy_Pred stays 0.
- Req = 1 at cycle 3 of a mult countdown -> countdown continues; Busy_Pred drops at cycle 6; MDU_Op = 0 in the Req cycle.
- Reset asserted at cnt = 7 of a div -> Busy_Pred = 0 and Stall = 0 one cycle after reset; Sync_Err = 0.
- Force MDU_Busy low one cycle early -> Sync_Err rises the next cycle and stays 1 until reset.
